// File: rtl/calc_result_display.sv
// Sign + 3-digit BCD display stage: serial double-dabble into a double-buffered 4-digit scanned panel.
// Define CALC_DISP_ZERO_BLANK_EN to suppress leading zeros on the two upper numeric digits.
module calc_result_display #(
    parameter int W        = 6,
    parameter int SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rs,
    input  logic [W-1:0] value,
    input  logic         load,
    output logic         busy,
    output logic         done,
    output logic [6:0]   seg,
    output logic [3:0]   an
);

    localparam int CW = $clog2(W + 1);
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t              state, state_next;
    logic                finish;
    logic                neg;
    logic [W-1:0]        mag;
    logic [11:0]         bcd, bcd_adj, bcd_shift;
    logic [CW-1:0]       cnt;
    logic [3:0]          d0, d1, d2;
    logic                dneg;
    logic [SCAN_DIV-1:0] presc;
    logic [1:0]          idx;
    logic                blank1, blank2;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) state <= IDLE;
        else     state <= state_next;
    end

    // A fresh load always wins, even on the edge that would otherwise complete a conversion.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_next = CONVERT;
            end
            CONVERT: begin
                if (load) begin
                    state_next = CONVERT;
                end else if (cnt == CW'(1)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CONVERT);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_shift = (bcd_adj << 1) | {11'd0, mag[W-1]};
    end

    // Display registers are only written on completion, so the panel never sees partial results.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            neg  <= 1'b0;
            mag  <= '0;
            bcd  <= '0;
            cnt  <= '0;
            d0   <= '0;
            d1   <= '0;
            d2   <= '0;
            dneg <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                neg <= value[W-1];
                mag <= value[W-1] ? (~value) + W'(1) : value;
                bcd <= '0;
                cnt <= CW'(W);
            end else if (state == CONVERT) begin
                bcd <= bcd_shift;
                mag <= mag << 1;
                cnt <= cnt - CW'(1);
                if (finish) {d2, d1, d0, dneg} <= {bcd_shift, neg};
            end
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + SCAN_DIV'(1);
            if (&presc) idx <= idx + 2'd1;
        end
    end

`ifdef CALC_DISP_ZERO_BLANK_EN
    assign blank2 = (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);
`else
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    always_comb begin
        an  = 4'b0001 << idx;
        seg = SEG_BLANK;
        case (idx)
            2'd0: seg = glyph(d0);
            2'd1: seg = blank1 ? SEG_BLANK : glyph(d1);
            2'd2: seg = blank2 ? SEG_BLANK : glyph(d2);
            2'd3: seg = dneg ? SEG_MINUS : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display: stimulus pushes expected done time and glyphs,
// per-DUT monitors pop on each done pulse and read the full scan back from an/seg.
module tb_calc_result_display;

    localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011, G3 = 7'b1001111;
    localparam logic [6:0] G5 = 7'b1101101, G9 = 7'b1101111;
    localparam logic [6:0] BLANK = 7'b0000000, MINUS = 7'b1000000;
`ifdef CALC_DISP_ZERO_BLANK_EN
    localparam logic [6:0] LZ = BLANK;
`else
    localparam logic [6:0] LZ = G0;
`endif

    logic       clk = 1'b0;
    logic       rs;
    logic [5:0] value6;
    logic       load6, busy6, done6;
    logic [6:0] seg6;
    logic [3:0] an6;
    logic [9:0] value10;
    logic       load10, busy10, done10;
    logic [6:0] seg10;
    logic [3:0] an10;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        logic [27:0] glyphs;
    } exp_t;

    exp_t q6[$];
    exp_t q10[$];
    bit   mon6_active = 1'b0;
    bit   mon10_active = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_result_display #(.W(6), .SCAN_DIV(1)) dut6 (
        .clk(clk), .rs(rs), .value(value6), .load(load6),
        .busy(busy6), .done(done6), .seg(seg6), .an(an6)
    );

    calc_result_display #(.W(10), .SCAN_DIV(1)) dut10 (
        .clk(clk), .rs(rs), .value(value10), .load(load10),
        .busy(busy10), .done(done10), .seg(seg10), .an(an10)
    );

    task automatic check_output(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic check_done(input string name, input exp_t e, input int got_cyc,
                              input logic [27:0] got, input bit extra);
        check_output({name, " done_time"}, got_cyc, e.cyc);
        check_output({name, " digits"}, int'(got), int'(e.glyphs));
        check_output({name, " single_pulse"}, int'(extra), 0);
    endtask

    // Must be called at a negedge; load is sampled at the following posedge.
    task automatic apply_stimulus(input bit wide, input int v, input bit expect_done,
                                  input logic [27:0] glyphs);
        exp_t e;
        e.cyc    = cyc + 1 + (wide ? 10 : 6);
        e.glyphs = glyphs;
        if (wide) begin
            value10 = v[9:0];
            load10  = 1'b1;
            if (expect_done) q10.push_back(e);
        end else begin
            value6 = v[5:0];
            load6  = 1'b1;
            if (expect_done) q6.push_back(e);
        end
        @(negedge clk);
        load6  = 1'b0;
        load10 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (q6.size() == 0 && q10.size() == 0 && !mon6_active && !mon10_active) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!idle) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: pending %0d/%0d, expected 0/0", name, q6.size(), q10.size());
            q6.delete();
            q10.delete();
        end
    endtask

    initial begin : mon6
        logic [27:0] got;
        bit          extra;
        int          dc;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (done6 === 1'b1) begin
                mon6_active = 1'b1;
                dc = cyc; got = '0; extra = 1'b0;
                if (q6.size() == 0) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL w6 unexpected_done: got done at cycle %0d, expected none", cyc);
                    e.cyc = -1; e.glyphs = '0;
                end else begin
                    e = q6.pop_front();
                end
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        if (done6) extra = 1'b1;
                    end
                    case (an6)
                        4'b0001: got[6:0]   = seg6;
                        4'b0010: got[13:7]  = seg6;
                        4'b0100: got[20:14] = seg6;
                        4'b1000: got[27:21] = seg6;
                        default: extra = 1'b1;
                    endcase
                end
                if (e.cyc >= 0) check_done("w6", e, dc, got, extra);
                mon6_active = 1'b0;
            end
        end
    end

    initial begin : mon10
        logic [27:0] got;
        bit          extra;
        int          dc;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (done10 === 1'b1) begin
                mon10_active = 1'b1;
                dc = cyc; got = '0; extra = 1'b0;
                if (q10.size() == 0) begin
                    vectors++; miscompares++;
                    $display("[TB] FAIL w10 unexpected_done: got done at cycle %0d, expected none", cyc);
                    e.cyc = -1; e.glyphs = '0;
                end else begin
                    e = q10.pop_front();
                end
                for (int k = 0; k < 8; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        if (done10) extra = 1'b1;
                    end
                    case (an10)
                        4'b0001: got[6:0]   = seg10;
                        4'b0010: got[13:7]  = seg10;
                        4'b0100: got[20:14] = seg10;
                        4'b1000: got[27:21] = seg10;
                        default: extra = 1'b1;
                    endcase
                end
                if (e.cyc >= 0) check_done("w10", e, dc, got, extra);
                mon10_active = 1'b0;
            end
        end
    end

    initial begin : stim
        int idx;
        rs = 1'b0; load6 = 1'b0; load10 = 1'b0; value6 = '0; value10 = '0;
        repeat (2) @(negedge clk);
        check_output("rst_busy", int'(busy6), 0);
        check_output("rst_done", int'(done6), 0);
        check_output("rst_an", int'(an6), 1);
        check_output("rst_seg", int'(seg6), int'(G0));
        check_output("rst_busy10", int'(busy10), 0);
        rs = 1'b1;

        // Scan with SCAN_DIV=1: each digit for two cycles, "0" on digits 0-2, blank on digit 3.
        for (int j = 0; j < 20; j++) begin
            idx = (j / 2) % 4;
            check_output("scan_an", int'(an6), 1 << idx);
            check_output("scan_seg", int'(seg6), (idx == 3) ? int'(BLANK) : int'(G0));
            @(negedge clk);
        end

        apply_stimulus(1'b0, -13, 1'b1, {MINUS, LZ, G1, G3});
        for (int k = 0; k < 6; k++) begin
            check_output("busy_high", int'(busy6), 1);
            @(negedge clk);
        end
        check_output("busy_low", int'(busy6), 0);
        wait_idle("m13");

        apply_stimulus(1'b0, -32, 1'b1, {MINUS, LZ, G3, G2});
        wait_idle("m32");
        apply_stimulus(1'b0, 31, 1'b1, {BLANK, LZ, G3, G1});
        wait_idle("p31");

        // Restart at edge 3: only the -5 conversion completes.
        apply_stimulus(1'b0, 31, 1'b0, '0);
        repeat (2) @(negedge clk);
        apply_stimulus(1'b0, -5, 1'b1, {MINUS, LZ, LZ, G5});
        wait_idle("restart");

        // Load on the completion edge wins; the 7 result is lost.
        apply_stimulus(1'b0, 7, 1'b0, '0);
        repeat (5) @(negedge clk);
        apply_stimulus(1'b0, 9, 1'b1, {BLANK, LZ, LZ, G9});
        wait_idle("load_at_done");

        // Reset during a conversion of -13.
        apply_stimulus(1'b0, -13, 1'b0, '0);
        @(negedge clk);
        rs = 1'b0;
        #1;
        check_output("midrst_busy", int'(busy6), 0);
        check_output("midrst_done", int'(done6), 0);
        check_output("midrst_an", int'(an6), 1);
        check_output("midrst_seg", int'(seg6), int'(G0));
        @(negedge clk);
        load6 = 1'b1; value6 = 6'b110011;
        @(negedge clk);
        load6 = 1'b0;
        rs = 1'b1;
        @(negedge clk);
        check_output("load_in_reset", int'(busy6), 0);
        repeat (12) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            case (an6)
                4'b1000: check_output("post_rst_d3", int'(seg6), int'(BLANK));
                4'b0100: check_output("post_rst_d2", int'(seg6), int'(LZ));
                4'b0010: check_output("post_rst_d1", int'(seg6), int'(LZ));
                default: check_output("post_rst_d0", int'(seg6), int'(G0));
            endcase
            @(negedge clk);
        end

        apply_stimulus(1'b1, -512, 1'b1, {MINUS, G5, G1, G2});
        wait_idle("m512");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
